// File: rtl/spwm_sequencer_pkg.sv
// Shared definitions for the SPWM run/stop sequencer: FSM state encodings,
// default widths and timing, and state-class helpers.
package spwm_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_ARM   = 3'd1,
    SEQ_RAMP  = 3'd2,
    SEQ_RUN   = 3'd3,
    SEQ_DECEL = 3'd4,
    SEQ_TRIP  = 3'd5
  } seq_state_e;

  localparam int DEF_ANGLE_W    = 12;
  localparam int DEF_INC_W      = 16;
  localparam int DEF_ACC_W      = 28;
  localparam int DEF_RAMP_DIV   = 48000;
  localparam int DEF_RAMP_STEP  = 4;
  localparam int DEF_ARM_CYCLES = 480;

  // States in which the gates are enabled and the increment is rate limited.
  function automatic logic is_running(seq_state_e s);
    return (s == SEQ_RAMP) || (s == SEQ_RUN) || (s == SEQ_DECEL);
  endfunction

  // States in which the modulators are held in reset with zero phase.
  function automatic logic is_parked(seq_state_e s);
    return (s == SEQ_IDLE) || (s == SEQ_TRIP);
  endfunction

endpackage

// File: rtl/spwm_sequencer_ramp_limiter.sv
// Rate limiter: a tick divider plus a clamped step of the current increment
// toward its target on every tick.
module spwm_sequencer_ramp_limiter
  import spwm_sequencer_pkg::*;
#(
  parameter int INC_W     = DEF_INC_W,
  parameter int RAMP_DIV  = DEF_RAMP_DIV,
  parameter int RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INC_W-1:0] target_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             flush_i,
  output logic [INC_W-1:0] cur_o,
  output logic             reached_o
);

  localparam int               DIV_W    = $clog2(RAMP_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [INC_W-1:0] STEP     = INC_W'(RAMP_STEP);

  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [INC_W-1:0] cur_q, cur_d;
  logic [INC_W-1:0] gap;
  logic             tick;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    tick       = en_i && (tick_cnt_q == DIV_LAST);
    tick_cnt_d = '0;
    if (en_i && !clr_i && !tick) tick_cnt_d = tick_cnt_q + DIV_W'(1);

    gap   = (cur_q > target_i) ? (cur_q - target_i) : (target_i - cur_q);
    cur_d = cur_q;
    if (flush_i) begin
      cur_d = '0;
    end else if (tick && (cur_q != target_i)) begin
      // Clamp the last step so the target is hit exactly, never crossed.
      if (gap <= STEP)            cur_d = target_i;
      else if (cur_q < target_i)  cur_d = cur_q + STEP;
      else                        cur_d = cur_q - STEP;
    end
  end

  // NOTE: clocked state is written with non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      cur_q      <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      cur_q      <= cur_d;
    end
  end

  assign cur_o     = cur_q;
  assign reached_o = (cur_q == target_i);

endmodule

// File: rtl/spwm_sequencer.sv
// Run/stop sequencer for the SPWM modulator bank: phase accumulator, soft start/stop and fault trip.
// Optional SPWM_SEQ_REVERSE_EN adds a `reverse` input that runs the accumulator downward in RUN.
module spwm_sequencer
  import spwm_sequencer_pkg::*;
#(
  parameter int ANGLE_W    = DEF_ANGLE_W,
  parameter int INC_W      = DEF_INC_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int RAMP_DIV   = DEF_RAMP_DIV,
  parameter int RAMP_STEP  = DEF_RAMP_STEP,
  parameter int ARM_CYCLES = DEF_ARM_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               fault,
  input  logic               fault_clr,
`ifdef SPWM_SEQ_REVERSE_EN
  input  logic               reverse,
`endif
  input  logic [INC_W-1:0]   freq_cmd,
  output logic [ANGLE_W-1:0] angle,
  output logic               shoot,
  output logic               mod_reset,
  output logic               at_speed,
  output logic               fault_latched,
  output logic [2:0]         state
);

  localparam int               ARM_W    = $clog2(ARM_CYCLES + 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);

  seq_state_e         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
  logic [ANGLE_W-1:0] angle_q;
  logic               shoot_q, mod_reset_q, at_speed_q, fault_latched_q;
  logic [INC_W-1:0]   inc_cur, ramp_target;
  logic               reached, count_down;

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = '0;
    if (fault && (state_q != SEQ_TRIP)) begin
      state_d = SEQ_TRIP;
    end else begin
      unique case (state_q)
        SEQ_IDLE:  if (start && !stop && !fault_latched_q) state_d = SEQ_ARM;
        SEQ_ARM: begin
          if (stop)                      state_d   = SEQ_IDLE;
          else if (arm_cnt_q == ARM_LAST) state_d  = SEQ_RAMP;
          else                           arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end
        SEQ_RAMP: begin
          if (stop)         state_d = SEQ_DECEL;
          else if (reached) state_d = SEQ_RUN;
        end
        SEQ_RUN:   if (stop) state_d = SEQ_DECEL;
        SEQ_DECEL: if (reached) state_d = SEQ_IDLE;
        SEQ_TRIP:  if (fault_clr && !fault) state_d = SEQ_IDLE;
        default:   state_d = SEQ_IDLE;
      endcase
    end
  end

  assign ramp_target = (state_q == SEQ_DECEL) ? '0 : freq_cmd;

  spwm_sequencer_ramp_limiter #(
    .INC_W     (INC_W),
    .RAMP_DIV  (RAMP_DIV),
    .RAMP_STEP (RAMP_STEP)
  ) u_ramp_limiter (
    .clk       (clk),
    .reset     (reset),
    .target_i  (ramp_target),
    .en_i      (is_running(state_q)),
    .clr_i     ((state_d != state_q) && is_running(state_d)),
    .flush_i   (is_parked(state_d)),
    .cur_o     (inc_cur),
    .reached_o (reached)
  );

`ifdef SPWM_SEQ_REVERSE_EN
  logic reverse_q;

  // Direction is latched before the gates open and frozen for the whole run.
  always_ff @(posedge clk) begin
    if (!reset)                                            reverse_q <= 1'b0;
    else if ((state_q == SEQ_IDLE) || (state_q == SEQ_ARM)) reverse_q <= reverse;
  end

  assign count_down = reverse_q && (state_q == SEQ_RUN);
`else
  assign count_down = 1'b0;
`endif

  always_comb begin
    if (is_parked(state_d)) acc_d = '0;
    else if (count_down)    acc_d = acc_q - ACC_W'(inc_cur);
    else                    acc_d = acc_q + ACC_W'(inc_cur);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= SEQ_IDLE;
      acc_q           <= '0;
      arm_cnt_q       <= '0;
      angle_q         <= '0;
      shoot_q         <= 1'b0;
      mod_reset_q     <= 1'b1;
      at_speed_q      <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      arm_cnt_q       <= arm_cnt_d;
      angle_q         <= acc_q[ACC_W-1 -: ANGLE_W];
      shoot_q         <= is_running(state_d);
      mod_reset_q     <= is_parked(state_d);
      at_speed_q      <= (state_d == SEQ_RUN) && (inc_cur == freq_cmd);
      fault_latched_q <= (state_d == SEQ_TRIP);
    end
  end

  assign angle         = angle_q;
  assign shoot         = shoot_q;
  assign mod_reset     = mod_reset_q;
  assign at_speed      = at_speed_q;
  assign fault_latched = fault_latched_q;
  assign state         = state_q;

endmodule

// File: tb/tb_spwm_sequencer.sv
// Self-checking bench for spwm_sequencer: cycle model compared every cycle plus
// hand-computed expectations for the directed scenarios.
module tb_spwm_sequencer;

  localparam int ANGLE_W    = 12;
  localparam int INC_W      = 16;
  localparam int ACC_W      = 18;
  localparam int RAMP_DIV   = 8;
  localparam int RAMP_STEP  = 4;
  localparam int ARM_CYCLES = 480;

  localparam int S_IDLE = 0, S_ARM = 1, S_RAMP = 2, S_RUN = 3, S_DECEL = 4, S_TRIP = 5;

  logic               clk = 1'b0;
  logic               reset, start, stop, fault, fault_clr;
  logic [INC_W-1:0]   freq_cmd;
  logic [ANGLE_W-1:0] angle;
  logic               shoot, mod_reset, at_speed, fault_latched;
  logic [2:0]         state;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  always #5 clk = ~clk;

  spwm_sequencer #(
    .ANGLE_W    (ANGLE_W),
    .INC_W      (INC_W),
    .ACC_W      (ACC_W),
    .RAMP_DIV   (RAMP_DIV),
    .RAMP_STEP  (RAMP_STEP),
    .ARM_CYCLES (ARM_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .freq_cmd      (freq_cmd),
    .angle         (angle),
    .shoot         (shoot),
    .mod_reset     (mod_reset),
    .at_speed      (at_speed),
    .fault_latched (fault_latched),
    .state         (state)
  );

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: st/age describe the phase of operation, inc is the
  // frequency actually applied, the rest are the expected registered outputs.
  typedef struct {
    int     st;
    int     age;
    int     inc;
    longint acc;
    int     angle;
    int     shoot;
    int     mod_reset;
    int     at_speed;
    int     fault_latched;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.st = S_IDLE; r.age = 0; r.inc = 0; r.acc = 0; r.angle = 0;
    r.shoot = 0; r.mod_reset = 1; r.at_speed = 0; r.fault_latched = 0;
    return r;
  endfunction

  function automatic model_t model_next(model_t c, logic st_v, logic sp_v, logic f_v, logic fc_v, int fcmd);
    model_t n;
    int     ns, tgt;
    bit     ramping, parked;
    n  = c;
    ns = c.st;
    if (f_v && c.st != S_TRIP) ns = S_TRIP;
    else if (c.st == S_IDLE  && st_v && !sp_v)              ns = S_ARM;
    else if (c.st == S_ARM   && sp_v)                        ns = S_IDLE;
    else if (c.st == S_ARM   && c.age == ARM_CYCLES - 1)     ns = S_RAMP;
    else if (c.st == S_RAMP  && sp_v)                        ns = S_DECEL;
    else if (c.st == S_RAMP  && c.inc == fcmd)               ns = S_RUN;
    else if (c.st == S_RUN   && sp_v)                        ns = S_DECEL;
    else if (c.st == S_DECEL && c.inc == 0)                  ns = S_IDLE;
    else if (c.st == S_TRIP  && fc_v && !f_v)                ns = S_IDLE;

    ramping = (c.st == S_RAMP || c.st == S_RUN || c.st == S_DECEL);
    parked  = (ns == S_IDLE || ns == S_TRIP);
    tgt     = (c.st == S_DECEL) ? 0 : fcmd;
    if (ramping && (c.age % RAMP_DIV) == RAMP_DIV - 1) begin
      if (c.inc < tgt)      n.inc = (tgt - c.inc > RAMP_STEP) ? c.inc + RAMP_STEP : tgt;
      else if (c.inc > tgt) n.inc = (c.inc - tgt > RAMP_STEP) ? c.inc - RAMP_STEP : tgt;
    end
    if (parked) n.inc = 0;

    n.acc           = parked ? 0 : (c.acc + c.inc) % (longint'(1) << ACC_W);
    n.angle         = int'(c.acc >> (ACC_W - ANGLE_W));
    n.shoot         = (ns == S_RAMP || ns == S_RUN || ns == S_DECEL);
    n.mod_reset     = parked;
    n.at_speed      = (ns == S_RUN) && (c.inc == fcmd);
    n.fault_latched = (ns == S_TRIP);
    n.age           = (ns == c.st) ? c.age + 1 : 0;
    n.st            = ns;
    return n;
  endfunction

  always @(posedge clk)
    m <= reset ? model_next(m, start, stop, fault, fault_clr, int'(freq_cmd)) : model_reset();

  always @(negedge clk) begin
    if (cmp_en) begin
      check("state",         state,         m.st);
      check("angle",         angle,         m.angle);
      check("shoot",         shoot,         m.shoot);
      check("mod_reset",     mod_reset,     m.mod_reset);
      check("at_speed",      at_speed,      m.at_speed);
      check("fault_latched", fault_latched, m.fault_latched);
    end
  end

  // Counts cycles spent in state s, starting on its first sampled cycle.
  task automatic measure(input int s, input int limit, output int n);
    n = 0;
    while (int'(state) == s && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int  len;
    bit  found;
    int  prev_angle, hold_angle;

    reset = 1'b0; start = 1'b0; stop = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    freq_cmd = 16'd40;
    cycles(3);
    check("rst_state",     state,         0);
    check("rst_mod_reset", mod_reset,     1);
    check("rst_shoot",     shoot,         0);
    check("rst_angle",     angle,         0);
    check("rst_at_speed",  at_speed,      0);
    check("rst_fault",     fault_latched, 0);
    reset  = 1'b1;
    cmp_en = 1'b1;
    cycles(2);

    // Soft start to 40: 480-cycle ARM, then ten ramp ticks.
    start = 1'b1;
    @(negedge clk);
    check("arm_state",     state,     1);
    check("arm_mod_reset", mod_reset, 0);
    check("arm_shoot",     shoot,     0);
    measure(S_ARM, 1000, len);
    check("arm_len", len, 480);
    check("ramp_shoot", shoot, 1);
    measure(S_RAMP, 1000, len);
    check("ramp_len", len, 10 * RAMP_DIV + 1);
    check("run_state",    state,    3);
    check("run_at_speed", at_speed, 1);

    // Command step down 40 -> 38 is absorbed by a single clamped tick.
    freq_cmd = 16'd38;
    @(negedge clk);
    check("step_at_speed_drop", at_speed, 0);
    found = 0;
    for (int i = 0; i < RAMP_DIV + 2 && !found; i++) begin
      @(negedge clk);
      if (at_speed) found = 1;
    end
    check("step_at_speed_back", found, 1);
    check("step_still_run", state, 3);

    freq_cmd = 16'd40;
    found = 0;
    for (int i = 0; i < RAMP_DIV + 3 && !found; i++) begin
      @(negedge clk);
      if (at_speed) found = 1;
    end
    check("step_up_at_speed", found, 1);

    // Accumulator wrap: angle must go straight from full scale to zero.
    found = 0;
    for (int i = 0; i < 10000 && !found; i++) begin
      prev_angle = int'(angle);
      @(negedge clk);
      if (prev_angle == 4095 && angle == 0) found = 1;
    end
    check("angle_wrap", found, 1);

    // Controlled stop from 40; start held high must not restart the cycle.
    stop = 1'b1;
    @(negedge clk);
    check("decel_state", state, 4);
    check("decel_shoot", shoot, 1);
    measure(S_DECEL, 1000, len);
    check("decel_len",       len,       10 * RAMP_DIV + 1);
    check("idle_shoot",      shoot,     0);
    check("idle_mod_reset",  mod_reset, 1);
    @(negedge clk);
    check("idle_stop_holds", state,     0);

    // Fault beats stop in RAMP, and only clears once the fault is gone.
    stop = 1'b0;
    @(negedge clk);
    measure(S_ARM, 1000, len);
    cycles(2);
    fault = 1'b1; stop = 1'b1;
    @(negedge clk);
    check("trip_state", state,         5);
    check("trip_shoot", shoot,         0);
    check("trip_latch", fault_latched, 1);
    check("trip_mreset", mod_reset,    1);
    stop = 1'b0; start = 1'b0; fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("clr_blocked_state", state,         5);
    check("clr_blocked_latch", fault_latched, 1);
    fault = 1'b0; fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("clr_state", state,         0);
    check("clr_latch", fault_latched, 0);

    // Zero command: RAMP lasts one cycle and the angle stays still.
    freq_cmd = 16'd0; start = 1'b1;
    @(negedge clk);
    measure(S_ARM, 1000, len);
    check("zero_ramp_state", state, 2);
    @(negedge clk);
    check("zero_run_state", state,    3);
    check("zero_at_speed",  at_speed, 1);
    hold_angle = int'(angle);
    cycles(20);
    check("zero_angle_hold", angle, hold_angle);

    // Reset mid-run returns every output to its reset value.
    freq_cmd = 16'd100;
    cycles(40);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_state",     state,         0);
    check("midrst_shoot",     shoot,         0);
    check("midrst_mod_reset", mod_reset,     1);
    check("midrst_angle",     angle,         0);
    check("midrst_at_speed",  at_speed,      0);
    check("midrst_fault",     fault_latched, 0);
    reset = 1'b1; start = 1'b0;
    cycles(5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
